// File: rtl/xgs_hispi_pkg.sv
// ============================================================================
// Module      : xgs_hispi_pkg
// Description : HiSPi packetized-SP sync codes and lane TX state encoding,
//               shared by the lane transmitter and the receiver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package xgs_hispi_pkg;

    localparam int PIX_W = 12;

    localparam logic [PIX_W-1:0] SYNC_FFF      = 12'hFFF;
    localparam logic [PIX_W-1:0] SYNC_000      = 12'h000;
    localparam logic [PIX_W-1:0] CODE_SOF      = 12'hC00;
    localparam logic [PIX_W-1:0] CODE_SOL      = 12'h800;
    localparam logic [PIX_W-1:0] CODE_EOL      = 12'hA00;
    localparam logic [PIX_W-1:0] CODE_EOF      = 12'hE00;
    localparam logic [PIX_W-1:0] PIX_CLIP      = 12'hFFE;
    localparam logic [PIX_W-1:0] UNDERRUN_WORD = 12'h001;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC_HEAD = 3'd1,
        ST_DATA      = 3'd2,
        ST_SYNC_TAIL = 3'd3,
        ST_BLANK     = 3'd4
    } hispi_tx_state_t;

    // Word at position idx of a 4-word sync sequence: FFF, 000, 000, code.
    function automatic logic [PIX_W-1:0] sync_word(input logic [1:0] idx,
                                                   input logic [PIX_W-1:0] code);
        logic [PIX_W-1:0] w;
        case (idx)
            2'd0:    w = SYNC_FFF;
            2'd3:    w = code;
            default: w = SYNC_000;
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xgs_hispi_tx_lane.sv
// ============================================================================
// Module      : xgs_hispi_tx_lane
// Description : HiSPi packetized-SP lane transmitter, one frame per start.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module xgs_hispi_tx_lane
    import xgs_hispi_pkg::*;
#(
    parameter logic [PIX_W-1:0] IDLE_WORD = 12'h3A6,
    parameter int               CNT_W     = 12
) (
    input  logic             sysclk,
    input  logic             sysrst_n,
    input  logic             tx_ce,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_line_words,
    input  logic [CNT_W-1:0] cfg_nb_lines,
    input  logic [CNT_W-1:0] cfg_blank_words,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] tx_word,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] line_cnt,
    output logic             underrun
);

    hispi_tx_state_t  r_state;
    logic [1:0]       r_sync_idx;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_line_words;
    logic [CNT_W-1:0] r_nb_lines;
    logic [CNT_W-1:0] r_blank_words;
    logic [PIX_W-1:0] r_tx_word;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_underrun;

    logic             w_cfg_ok;
    logic             w_last_col;
    logic             w_last_line;
    logic             w_blank_done;
    logic [PIX_W-1:0] w_head_word;
    logic [PIX_W-1:0] w_tail_word;
    logic [PIX_W-1:0] w_pix_word;

    assign w_cfg_ok     = (cfg_line_words != '0) && (cfg_nb_lines != '0);
    assign w_last_col   = (r_word_cnt == r_line_words - CNT_W'(1));
    assign w_last_line  = (r_line_cnt == r_nb_lines - CNT_W'(1));
    assign w_blank_done = (r_word_cnt == r_blank_words);
    assign w_head_word  = sync_word(r_sync_idx, (r_line_cnt == '0) ? CODE_SOF : CODE_SOL);
    assign w_tail_word  = sync_word(r_sync_idx, w_last_line ? CODE_EOF : CODE_EOL);
    // 0xFFF is reserved for sync headers, so pixels saturate one below it.
    assign w_pix_word   = !pix_valid ? UNDERRUN_WORD :
                          (pix_data == SYNC_FFF) ? PIX_CLIP : pix_data;

    assign pix_ready  = (r_state == ST_DATA) && tx_ce;
    assign tx_word    = r_tx_word;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign line_cnt   = r_line_cnt;
    assign underrun   = r_underrun;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state       <= ST_IDLE;
            r_sync_idx    <= 2'd0;
            r_word_cnt    <= '0;
            r_line_cnt    <= '0;
            r_line_words  <= '0;
            r_nb_lines    <= '0;
            r_blank_words <= '0;
            r_tx_word     <= IDLE_WORD;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (tx_ce) begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx_word  <= IDLE_WORD;
                        r_line_cnt <= '0;
                        // The accepting edge already emits the first FFF.
                        if (start && w_cfg_ok) begin
                            r_line_words  <= cfg_line_words;
                            r_nb_lines    <= cfg_nb_lines;
                            r_blank_words <= cfg_blank_words;
                            r_tx_word     <= SYNC_FFF;
                            r_sync_idx    <= 2'd1;
                            r_busy        <= 1'b1;
                            r_underrun    <= 1'b0;
                            r_state       <= ST_SYNC_HEAD;
                        end
                    end
                    ST_SYNC_HEAD: begin
                        r_tx_word  <= w_head_word;
                        r_sync_idx <= r_sync_idx + 2'd1;
                        if (r_sync_idx == 2'd3) begin
                            r_word_cnt <= '0;
                            r_state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_tx_word  <= w_pix_word;
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        if (!pix_valid) begin
                            r_underrun <= 1'b1;
                        end
                        if (w_last_col) begin
                            r_sync_idx <= 2'd0;
                            r_state    <= ST_SYNC_TAIL;
                        end
                    end
                    ST_SYNC_TAIL: begin
                        r_tx_word  <= w_tail_word;
                        r_sync_idx <= r_sync_idx + 2'd1;
                        if (r_sync_idx == 2'd3) begin
                            r_word_cnt <= '0;
                            r_state    <= ST_BLANK;
                        end
                    end
                    ST_BLANK: begin
                        // The edge leaving blanking emits the next line's FFF
                        // directly, so zero blank words cost no word slot.
                        if (!w_blank_done) begin
                            r_tx_word  <= IDLE_WORD;
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end else if (w_last_line) begin
                            r_tx_word    <= IDLE_WORD;
                            r_line_cnt   <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_tx_word  <= SYNC_FFF;
                            r_sync_idx <= 2'd1;
                            r_line_cnt <= r_line_cnt + CNT_W'(1);
                            r_state    <= ST_SYNC_HEAD;
                        end
                    end
                    default: begin
                        r_tx_word <= IDLE_WORD;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xgs_hispi_tx_lane.sv
// ============================================================================
// Module      : tb_xgs_hispi_tx_lane
// Description : Self-checking bench for the HiSPi lane transmitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_xgs_hispi_tx_lane;
    import xgs_hispi_pkg::*;

    localparam int          CNT_W  = 12;
    localparam logic [11:0] IDLE_W = 12'h3A6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_ce = 1'b0;
    logic        start = 1'b0;
    logic [11:0] lw = 12'd0;
    logic [11:0] nl = 12'd0;
    logic [11:0] bw = 12'd0;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] tx_word;
    logic        busy;
    logic        frame_done;
    logic [11:0] line_cnt;
    logic        underrun;

    xgs_hispi_tx_lane #(.IDLE_WORD(IDLE_W), .CNT_W(CNT_W)) dut (
        .sysclk(clk), .sysrst_n(rst_n), .tx_ce(tx_ce), .start(start),
        .cfg_line_words(lw), .cfg_nb_lines(nl), .cfg_blank_words(bw),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .tx_word(tx_word), .busy(busy), .frame_done(frame_done),
        .line_cnt(line_cnt), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel source: value depends on the data-slot index within the frame.
    int d_idx = 0;
    bit d_clr = 1'b0;
    int base = 0;
    int drop_idx = -1;
    int fff_idx = -1;
    always @(posedge clk) begin
        if (d_clr) d_idx <= 0;
        else if (pix_ready) d_idx <= d_idx + 1;
    end
    always_comb begin
        pix_valid = (d_idx != drop_idx);
        pix_data  = (d_idx == fff_idx) ? 12'hFFF : 12'(base + d_idx);
    end

    // Reference model: the whole frame as a list of word slots.
    typedef struct {
        bit          is_data;
        logic [11:0] w;
        int          line;
    } slot_t;
    slot_t       q[$];
    int          m_ptr = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_under = 1'b0;
    logic [11:0] m_word = IDLE_W;
    int          m_line = 0;

    function automatic void push(input bit d, input logic [11:0] w, input int l);
        slot_t s;
        s.is_data = d;
        s.w       = w;
        s.line    = l;
        q.push_back(s);
    endfunction

    function automatic void build(input int nlw, input int nnl, input int nbw);
        q.delete();
        for (int l = 0; l < nnl; l++) begin
            push(0, 12'hFFF, l); push(0, 12'h000, l); push(0, 12'h000, l);
            push(0, (l == 0) ? 12'hC00 : 12'h800, l);
            for (int d = 0; d < nlw; d++) push(1, 12'h000, l);
            push(0, 12'hFFF, l); push(0, 12'h000, l); push(0, 12'h000, l);
            push(0, (l == nnl - 1) ? 12'hE00 : 12'hA00, l);
            for (int b = 0; b < nbw; b++) push(0, IDLE_W, l);
        end
    endfunction

    function automatic void emit();
        m_line = q[m_ptr].line;
        if (!q[m_ptr].is_data) begin
            m_word = q[m_ptr].w;
        end else if (!pix_valid) begin
            m_word  = 12'h001;
            m_under = 1'b1;
        end else begin
            m_word = (pix_data == 12'hFFF) ? 12'hFFE : pix_data;
        end
    endfunction

    function automatic bit m_ready();
        if (!tx_ce || !m_busy || (m_ptr + 1 >= q.size())) return 1'b0;
        return q[m_ptr + 1].is_data;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ptr = 0; m_busy = 0; m_done = 0; m_under = 0;
            m_word = IDLE_W; m_line = 0;
        end else begin
            m_done = 1'b0;
            if (tx_ce) begin
                if (!m_busy) begin
                    m_word = IDLE_W;
                    m_line = 0;
                    if (start && lw != 0 && nl != 0) begin
                        build(int'(lw), int'(nl), int'(bw));
                        m_busy = 1'b1; m_under = 1'b0; m_ptr = 0;
                        emit();
                    end
                end else begin
                    m_ptr++;
                    if (m_ptr >= q.size()) begin
                        m_busy = 1'b0; m_done = 1'b1; m_word = IDLE_W; m_line = 0;
                    end else begin
                        emit();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_word",    32'(tx_word),    32'(m_word));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("line_cnt",   32'(line_cnt),   32'(m_line));
            chk("underrun",   32'(underrun),   32'(m_under));
            chk("pix_ready",  32'(pix_ready),  32'(m_ready()));
        end
    end

    // Capture of words emitted on tx_ce edges while a frame is in flight.
    logic        ce_prev = 1'b0;
    bit          cap_clr = 1'b0;
    logic [11:0] cap[$];
    int          done_cnt = 0;
    int          done_at = -1;
    always @(posedge clk) ce_prev <= tx_ce;
    always @(negedge clk) begin
        if (cap_clr) begin
            cap.delete();
            done_cnt = 0;
            done_at  = -1;
        end
        if (ce_prev && busy) cap.push_back(tx_word);
        if (frame_done) begin
            done_cnt++;
            done_at = cap.size();
        end
    end

    logic [11:0] exp_a [28] = '{12'hFFF, 12'h000, 12'h000, 12'hC00,
                                12'h100, 12'h101, 12'h102, 12'h103,
                                12'hFFF, 12'h000, 12'h000, 12'hA00, 12'h3A6, 12'h3A6,
                                12'hFFF, 12'h000, 12'h000, 12'h800,
                                12'h104, 12'h105, 12'h106, 12'h107,
                                12'hFFF, 12'h000, 12'h000, 12'hE00, 12'h3A6, 12'h3A6};
    logic [11:0] exp_d [22] = '{12'hFFF, 12'h000, 12'h000, 12'hC00,
                                12'hFFE, 12'h201, 12'h202,
                                12'hFFF, 12'h000, 12'h000, 12'hA00,
                                12'hFFF, 12'h000, 12'h000, 12'h800,
                                12'h203, 12'h204, 12'h205,
                                12'hFFF, 12'h000, 12'h000, 12'hE00};
    logic [11:0] exp_f [13] = '{12'hFFF, 12'h000, 12'h000, 12'hC00,
                                12'h300, 12'h301, 12'h302, 12'h303,
                                12'hFFF, 12'h000, 12'h000, 12'hE00, 12'h3A6};

    function automatic logic [31:0] cap_at(input int i);
        if (i < cap.size()) return 32'(cap[i]);
        return 32'hDEAD;
    endfunction

    task automatic start_frame(input int l, input int n, input int b);
        lw = 12'(l); nl = 12'(n); bw = 12'(b);
        start = 1'b1; tx_ce = 1'b1; d_clr = 1'b1; cap_clr = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; d_clr = 1'b0; cap_clr = 1'b0;
    endtask

    // Runs until busy falls; cfg is scrambled mid-frame to prove it was latched.
    task automatic wait_done(input bit toggle, output int cyc);
        cyc = 0;
        while (busy && cyc < 400) begin
            tx_ce = toggle ? ~tx_ce : 1'b1;
            if (cyc == 2) begin
                lw = 12'd9; nl = 12'd5; bw = 12'd3;
            end
            @(negedge clk); #1;
            cyc++;
        end
        chk("frame_timeout", 32'(busy), 32'd0);
        tx_ce = 1'b1;
    endtask

    int cyc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_word",    32'(tx_word),    32'h3A6);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_line_cnt",   32'(line_cnt),   32'd0);
        chk("rst_underrun",   32'(underrun),   32'd0);
        chk("rst_pix_ready",  32'(pix_ready),  32'd0);
        #1;
        rst_n = 1'b1;
        tx_ce = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Basic 4x2 frame with 2 blank words.
        base = 12'h100;
        start_frame(4, 2, 2);
        wait_done(1'b0, cyc);
        chk("a_cycles", 32'(cyc), 32'd28);
        for (int i = 0; i < 28; i++) chk("a_stream", cap_at(i), 32'(exp_a[i]));
        chk("a_done_cnt", 32'(done_cnt), 32'd1);
        chk("a_done_at", 32'(done_at), 32'd28);
        repeat (2) @(negedge clk);
        #1;

        // Same frame with tx_ce toggling.
        start_frame(4, 2, 2);
        wait_done(1'b1, cyc);
        chk("b_cycles", 32'(cyc), 32'd56);
        for (int i = 0; i < 28; i++) chk("b_stream", cap_at(i), 32'(exp_a[i]));
        chk("b_done_cnt", 32'(done_cnt), 32'd1);
        repeat (2) @(negedge clk);
        #1;

        // Underrun on the second data word.
        drop_idx = 1;
        start_frame(4, 2, 2);
        wait_done(1'b0, cyc);
        chk("c_len", 32'(cap.size()), 32'd28);
        chk("c_slot", cap_at(5), 32'h001);
        chk("c_next", cap_at(6), 32'h102);
        repeat (3) @(negedge clk);
        chk("c_sticky", 32'(underrun), 32'd1);
        #1;
        drop_idx = -1;

        // Clipping and zero blanking; the new start clears underrun.
        fff_idx = 0;
        base = 12'h200;
        start_frame(3, 2, 0);
        chk("d_uclr", 32'(underrun), 32'd0);
        wait_done(1'b0, cyc);
        chk("d_cycles", 32'(cyc), 32'd22);
        for (int i = 0; i < 22; i++) chk("d_stream", cap_at(i), 32'(exp_d[i]));
        fff_idx = -1;
        repeat (2) @(negedge clk);
        #1;

        // Starts with a zero config are ignored.
        cap_clr = 1'b1;
        @(negedge clk); #1;
        cap_clr = 1'b0;
        lw = 12'd4; nl = 12'd0; bw = 12'd1; start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        lw = 12'd0; nl = 12'd2;
        repeat (3) @(negedge clk);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_nosync", 32'(cap.size()), 32'd0);
        #1;
        start = 1'b0;

        // start held high during a frame is ignored while busy.
        start_frame(2, 1, 1);
        start = 1'b1;
        wait_done(1'b0, cyc);
        start = 1'b0;
        chk("e_cycles", 32'(cyc), 32'd11);
        chk("e_len", 32'(cap.size()), 32'd11);
        chk("e_done_cnt", 32'(done_cnt), 32'd1);
        repeat (3) @(negedge clk);
        chk("e_idle", 32'(busy), 32'd0);
        #1;

        // Asynchronous reset during DATA of line 1.
        base = 12'h300;
        start_frame(4, 2, 2);
        cyc = 0;
        while (!(line_cnt == 12'd1 && pix_ready) && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("f_reached", 32'(cyc < 100), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_tx_word",  32'(tx_word),  32'h3A6);
        chk("f_busy",     32'(busy),     32'd0);
        chk("f_line_cnt", 32'(line_cnt), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        start_frame(4, 1, 1);
        wait_done(1'b0, cyc);
        chk("f_cycles", 32'(cyc), 32'd13);
        for (int i = 0; i < 13; i++) chk("f_stream", cap_at(i), 32'(exp_f[i]));
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
